// File: rtl/vga_pkg.sv
// Shared constants, key-FSM encoding and sprite position payload for the
// VGA sprite overlay.
package vga_pkg;

  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned SCREEN_H    = 480;
  localparam int unsigned SPRITE_DIM  = 50;
  localparam int unsigned STEP        = 1;
  localparam int unsigned HOLD_FRAMES = 8;
  localparam int unsigned FIRST_GLYPH = 33;
  localparam int unsigned GLYPH_COUNT = 94;

  localparam logic [7:0]  PS2_BREAK   = 8'hF0;

  localparam int unsigned X_W     = 10;
  localparam int unsigned Y_W     = 9;
  localparam int unsigned GLYPH_W = 7;
  localparam int unsigned POS_W   = 11;
  localparam int unsigned HOLD_W  = 4;

  localparam int unsigned X_MAX = SCREEN_W - SPRITE_DIM;
  localparam int unsigned Y_MAX = SCREEN_H - SPRITE_DIM;
  localparam int unsigned X_RST = X_MAX / 2;
  localparam int unsigned Y_RST = Y_MAX / 2;

  typedef enum logic [1:0] {
    K_IDLE  = 2'd0,
    K_BREAK = 2'd1,
    K_PEND  = 2'd2
  } key_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } sprite_pos_t;

endpackage

// File: rtl/ps2_key_filter.sv
// PS/2 byte filter: drops break sequences and out-of-range codes, and holds
// one glyph until a frame boundary takes it.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   frame_i             frame-boundary edge cycle
//   key_valid_i         received byte strobe
//   key_code_i          received byte
//   key_ready_o         a new byte can be accepted
//   pend_valid_o        a glyph is waiting for the next frame
//   pend_glyph_o        waiting glyph number
module ps2_key_filter
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_i,
  input  logic               key_valid_i,
  input  logic [7:0]         key_code_i,
  output logic               key_ready_o,
  output logic               pend_valid_o,
  output logic [GLYPH_W-1:0] pend_glyph_o
);

  key_state_t         state_q;
  logic               ready_q;
  logic               pend_q;
  logic [GLYPH_W-1:0] glyph_q;
  logic               accept;
  logic               in_range;

  assign accept   = key_valid_i & ready_q;
  assign in_range = (key_code_i >= 8'(FIRST_GLYPH)) &&
                    (key_code_i <= 8'(FIRST_GLYPH + GLYPH_COUNT - 1));

  // Key FSM; K_PEND waits one extra cycle after the frame takes the glyph so
  // key_ready comes back two cycles after the frame edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= K_IDLE;
      ready_q <= 1'b1;
      pend_q  <= 1'b0;
      glyph_q <= '0;
    end else begin
      case (state_q)
        K_IDLE: begin
          if (accept) begin
            if (key_code_i == PS2_BREAK) begin
              state_q <= K_BREAK;
            end else if (in_range) begin
              state_q <= K_PEND;
              ready_q <= 1'b0;
              pend_q  <= 1'b1;
              glyph_q <= GLYPH_W'(key_code_i - 8'(FIRST_GLYPH));
            end
          end
        end
        K_BREAK: begin
          if (accept) state_q <= K_IDLE;
        end
        K_PEND: begin
          if (!pend_q) begin
            state_q <= K_IDLE;
            ready_q <= 1'b1;
          end else if (frame_i) begin
            pend_q <= 1'b0;
          end
        end
        default: begin
          state_q <= K_IDLE;
          ready_q <= 1'b1;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign key_ready_o  = ready_q;
  assign pend_valid_o = pend_q;
  assign pend_glyph_o = glyph_q;

endmodule

// File: rtl/sprite_frame_scheduler.sv
// Sprite position and glyph owner for the VGA overlay: gathers button and
// PS/2 requests and applies them as one atomic update per frame edge.
// Ports:
//   clk, reset              clock, async active-low reset
//   screenEnd               frame-boundary strobe (may be high several cycles)
//   btn_up/down/left/right  raw async buttons
//   key_valid, key_code     PS/2 byte strobe and data
//   key_ready               a new key byte can be accepted
//   sprite_x, sprite_y      committed sprite top-left corner
//   glyph_index, glyph_valid committed glyph and "any glyph committed"
//   commit                  one-cycle pulse on each frame update
// Build option: define SPRITE_WRAP_EN to wrap the position at the screen
// edges instead of clamping.
module sprite_frame_scheduler
  import vga_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               screenEnd,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  output logic               key_ready,
  output logic [X_W-1:0]     sprite_x,
  output logic [Y_W-1:0]     sprite_y,
  output logic [GLYPH_W-1:0] glyph_index,
  output logic               glyph_valid,
  output logic               commit
);

  // One axis step: opposite requests cancel, then clamp or wrap to [0, lim].
  function automatic logic [POS_W-1:0] move_axis(
    input logic [POS_W-1:0] cur,
    input logic             dec,
    input logic             inc,
    input logic [POS_W-1:0] step,
    input logic [POS_W-1:0] lim
  );
    logic signed [POS_W-1:0] nxt;
    nxt = $signed(cur);
    if (dec && !inc)      nxt = $signed(cur) - $signed(step);
    else if (inc && !dec) nxt = $signed(cur) + $signed(step);
`ifdef SPRITE_WRAP_EN
    if (nxt < 0)                 nxt = $signed(lim);
    else if (nxt > $signed(lim)) nxt = '0;
`else
    if (nxt < 0)                 nxt = '0;
    else if (nxt > $signed(lim)) nxt = $signed(lim);
`endif
    return $unsigned(nxt);
  endfunction

  logic [3:0]         btn_meta_q;  // {up, down, left, right}
  logic [3:0]         btn_sync_q;
  logic               se_q;
  logic               frame_edge;
  sprite_pos_t        pos_q, pos_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [GLYPH_W-1:0] glyph_q;
  logic               glyph_valid_q;
  logic               commit_q;
  logic [POS_W-1:0]   step;
  logic [POS_W-1:0]   x_next, y_next;
  logic               pend_valid;
  logic [GLYPH_W-1:0] pend_glyph;

  // Button synchronisers and screenEnd edge history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_q <= '0;
      btn_sync_q <= '0;
      se_q       <= 1'b0;
    end else begin
      btn_meta_q <= {btn_up, btn_down, btn_left, btn_right};
      btn_sync_q <= btn_meta_q;
      se_q       <= screenEnd;
    end
  end

  assign frame_edge = screenEnd & ~se_q;

  // Next position and hold count; step uses the count before this frame.
  always_comb begin
    step     = (hold_q == HOLD_W'(HOLD_FRAMES)) ? POS_W'(2 * STEP) : POS_W'(STEP);
    x_next   = move_axis(POS_W'(pos_q.x), btn_sync_q[1], btn_sync_q[0], step, POS_W'(X_MAX));
    y_next   = move_axis(POS_W'(pos_q.y), btn_sync_q[3], btn_sync_q[2], step, POS_W'(Y_MAX));
    pos_d.x  = X_W'(x_next);
    pos_d.y  = Y_W'(y_next);
    hold_d   = '0;
    if (|btn_sync_q) begin
      hold_d = (hold_q == HOLD_W'(HOLD_FRAMES)) ? hold_q : hold_q + HOLD_W'(1);
    end
  end

  // Commit registers: everything visible to the pixel path changes together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q         <= '{x: X_W'(X_RST), y: Y_W'(Y_RST)};
      hold_q        <= '0;
      glyph_q       <= '0;
      glyph_valid_q <= 1'b0;
      commit_q      <= 1'b0;
    end else begin
      commit_q <= frame_edge;
      if (frame_edge) begin
        pos_q  <= pos_d;
        hold_q <= hold_d;
        if (pend_valid) begin
          glyph_q       <= pend_glyph;
          glyph_valid_q <= 1'b1;
        end
      end
    end
  end

  ps2_key_filter u_key_filter (
    .clk          (clk),
    .rst_n        (reset),
    .frame_i      (frame_edge),
    .key_valid_i  (key_valid),
    .key_code_i   (key_code),
    .key_ready_o  (key_ready),
    .pend_valid_o (pend_valid),
    .pend_glyph_o (pend_glyph)
  );

  assign sprite_x    = pos_q.x;
  assign sprite_y    = pos_q.y;
  assign glyph_index = glyph_q;
  assign glyph_valid = glyph_valid_q;
  assign commit      = commit_q;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Scoreboard bench for sprite_frame_scheduler: a behavioural model pushes the
// expected frame state when screenEnd is driven; a monitor pops and compares
// on every commit pulse and checks outputs hold still between commits.
module tb_sprite_frame_scheduler;

  logic       clk;
  logic       reset;
  logic       screenEnd;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ready;
  logic [9:0] sprite_x;
  logic [8:0] sprite_y;
  logic [6:0] glyph_index;
  logic       glyph_valid;
  logic       commit;

  sprite_frame_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .screenEnd   (screenEnd),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .glyph_index (glyph_index),
    .glyph_valid (glyph_valid),
    .commit      (commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int g;
    int gv;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int m_x, m_y, m_hold, m_glyph, m_gv, m_kst, m_pglyph;
  // Last committed values, for the between-commit stability check
  int l_x, l_y, l_g, l_gv;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int fix(input int v, input int lim);
`ifdef SPRITE_WRAP_EN
    if (v < 0)   return lim;
    if (v > lim) return 0;
    return v;
`else
    if (v < 0)   return 0;
    if (v > lim) return lim;
    return v;
`endif
  endfunction

  task automatic model_reset();
    m_x = 295; m_y = 215; m_hold = 0; m_glyph = 0; m_gv = 0; m_kst = 0; m_pglyph = 0;
    l_x = 295; l_y = 215; l_g = 0; l_gv = 0;
  endtask

  task automatic model_frame(output exp_t e);
    int st, dx, dy;
    st = (m_hold == 8) ? 2 : 1;
    dx = 0;
    dy = 0;
    if (btn_right && !btn_left)      dx = st;
    else if (btn_left && !btn_right) dx = -st;
    if (btn_down && !btn_up)         dy = st;
    else if (btn_up && !btn_down)    dy = -st;
    m_x = fix(m_x + dx, 590);
    m_y = fix(m_y + dy, 430);
    if (btn_up || btn_down || btn_left || btn_right) m_hold = (m_hold < 8) ? m_hold + 1 : 8;
    else                                             m_hold = 0;
    if (m_kst == 2) begin
      m_glyph = m_pglyph;
      m_gv    = 1;
      m_kst   = 0;
    end
    e = '{x: m_x, y: m_y, g: m_glyph, gv: m_gv};
  endtask

  task automatic model_key(input logic [7:0] c);
    case (m_kst)
      0: begin
        if (c == 8'hF0) m_kst = 1;
        else if (c >= 8'd33 && c <= 8'd126) begin
          m_pglyph = int'(c) - 33;
          m_kst    = 2;
        end
      end
      1:       m_kst = 0;
      default: ;
    endcase
  endtask

  // Monitor: compare on each commit, otherwise outputs must not move.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      if (commit) begin
        if (sb_q.size() == 0) begin
          check_eq("unexpected_commit", 32'(commit), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("sprite_x", 32'(sprite_x), mon_e.x);
          check_eq("sprite_y", 32'(sprite_y), mon_e.y);
          check_eq("glyph_index", 32'(glyph_index), mon_e.g);
          check_eq("glyph_valid", 32'(glyph_valid), mon_e.gv);
          l_x = mon_e.x; l_y = mon_e.y; l_g = mon_e.g; l_gv = mon_e.gv;
        end
      end else begin
        check_eq("stable", 32'({sprite_x, sprite_y, glyph_index, glyph_valid}),
                 32'({10'(l_x), 9'(l_y), 7'(l_g), 1'(l_gv)}));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    screenEnd = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    model_reset();
    sb_q.delete();
    #1;
    check_eq("rst_x", 32'(sprite_x), 32'd295);
    check_eq("rst_y", 32'(sprite_y), 32'd215);
    check_eq("rst_glyph", 32'(glyph_index), 32'd0);
    check_eq("rst_gvalid", 32'(glyph_valid), 32'd0);
    check_eq("rst_commit", 32'(commit), 32'd0);
    check_eq("rst_ready", 32'(key_ready), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_btn(input logic [3:0] udlr);
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = udlr;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_key(input logic [7:0] c);
    @(negedge clk);
    check_eq("key_ready", 32'(key_ready), 32'(m_kst != 2));
    key_valid = 1'b1;
    key_code  = c;
    model_key(c);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // One frame edge; screenEnd stays high two cycles. Optional key on cycle E.
  task automatic frame(input bit with_key = 1'b0, input logic [7:0] c = 8'h00);
    exp_t e;
    bit   had_pend;
    @(negedge clk);
    if (with_key) check_eq("key_ready_e", 32'(key_ready), 32'(m_kst != 2));
    had_pend = (m_kst == 2);
    model_frame(e);
    sb_q.push_back(e);
    if (with_key) model_key(c);
    screenEnd = 1'b1;
    key_valid = with_key;
    key_code  = c;
    @(posedge clk); #1;
    check_eq("commit_latency", 32'(commit), 32'd1);
    if (had_pend) check_eq("ready_e1", 32'(key_ready), 32'd0);
    key_valid = 1'b0;
    @(posedge clk); #1;
    if (had_pend) check_eq("ready_e2", 32'(key_ready), 32'd1);
    @(negedge clk);
    screenEnd = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    screenEnd = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    key_valid = 1'b0;
    key_code  = 8'h00;

    // T1: idle frame
    do_reset();
    frame();
    check_eq("t1_x", 32'(sprite_x), 32'd295);
    check_eq("t1_gvalid", 32'(glyph_valid), 32'd0);

    // T2: right held 10 frames, then left+right cancels
    do_reset();
    set_btn(4'b0001);
    frames(10);
    check_eq("t2_x", 32'(sprite_x), 32'd307);
    check_eq("t2_gvalid", 32'(glyph_valid), 32'd0);
    set_btn(4'b0011);
    frame();
    check_eq("t2_cancel_x", 32'(sprite_x), 32'd307);

    // T3: left down to the edge, up+down held so y never moves
    do_reset();
    set_btn(4'b1110);
    frames(151);
    check_eq("t3_x1", 32'(sprite_x), 32'd1);
    check_eq("t3_y", 32'(sprite_y), 32'd215);
    set_btn(4'b0000);
    frame();
    set_btn(4'b0010);
    frame();
    check_eq("t3_x0", 32'(sprite_x), 32'd0);
    frame();
`ifdef SPRITE_WRAP_EN
    check_eq("t3_edge_x", 32'(sprite_x), 32'd590);
`else
    check_eq("t3_edge_x", 32'(sprite_x), 32'd0);
`endif

    // Top edge on y, right edge on x
    do_reset();
    set_btn(4'b1000);
    frames(112);
`ifdef SPRITE_WRAP_EN
    check_eq("top_edge_y", 32'(sprite_y), 32'd430);
`else
    check_eq("top_edge_y", 32'(sprite_y), 32'd0);
`endif
    do_reset();
    set_btn(4'b0001);
    frames(152);
`ifdef SPRITE_WRAP_EN
    check_eq("right_edge_x", 32'(sprite_x), 32'd0);
`else
    check_eq("right_edge_x", 32'(sprite_x), 32'd590);
`endif

    // T4: one key, committed at the next frame
    do_reset();
    send_key(8'h41);
    frame();
    check_eq("t4_glyph", 32'(glyph_index), 32'd32);
    check_eq("t4_gvalid", 32'(glyph_valid), 32'd1);

    // Key arriving on the edge cycle lands one frame later
    frame(1'b1, 8'h43);
    check_eq("edge_key_hold", 32'(glyph_index), 32'd32);
    frame();
    check_eq("edge_key_next", 32'(glyph_index), 32'd34);

    // Out-of-range codes dropped; range ends accepted
    send_key(8'h20);
    send_key(8'h7F);
    send_key(8'h21);
    frame();
    check_eq("low_end", 32'(glyph_index), 32'd0);
    send_key(8'h7E);
    frame();
    check_eq("high_end", 32'(glyph_index), 32'd93);

    // T5: break sequence discarded, FSM idle again
    send_key(8'hF0);
    send_key(8'h41);
    frame();
    check_eq("t5_glyph", 32'(glyph_index), 32'd93);
    send_key(8'h42);
    frame();
    check_eq("t5_after", 32'(glyph_index), 32'd33);

    // T6: second key while pending is dropped; reset loses a pending key
    send_key(8'h41);
    send_key(8'h42);
    frame();
    check_eq("t6_glyph", 32'(glyph_index), 32'd32);
    send_key(8'h44);
    do_reset();
    frame();
    check_eq("t6_lost_gvalid", 32'(glyph_valid), 32'd0);
    check_eq("t6_lost_glyph", 32'(glyph_index), 32'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
